// File: rtl/mesi_snoop_bus.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mesi_snoop_bus                                                           |
// | Round-robin MESI snooping bus: arbitration, snoop broadcast, transfer.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mesi_snoop_bus #(
    parameter int NCORES    = 4,
    parameter int TAG_W     = 17,
    parameter int IDX_W     = 10,
    parameter int MEM_LAT   = 8,
    parameter int FLUSH_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCORES-1:0]          req_valid_i,
    input  logic [2*NCORES-1:0]        req_type_i,
    input  logic [TAG_W*NCORES-1:0]    req_tag_i,
    input  logic [IDX_W*NCORES-1:0]    req_index_i,
    output logic [NCORES-1:0]          bus_ready_o,
    output logic [NCORES-1:0]          grant_o,
    output logic                       snoop_valid_o,
    output logic [1:0]                 snoop_type_o,
    output logic [TAG_W-1:0]           snoop_tag_o,
    output logic [IDX_W-1:0]           snoop_index_o,
    output logic [$clog2(NCORES)-1:0]  snoop_src_o,
    input  logic [NCORES-1:0]          snoop_hit_i,
    input  logic [NCORES-1:0]          snoop_dirty_i,
    output logic [NCORES-1:0]          done_o,
    output logic                       shared_o,
    output logic [31:0]                txn_cnt_o
);

    localparam int SRC_W   = $clog2(NCORES);
    localparam int MAX_LAT = (MEM_LAT > FLUSH_LAT) ? MEM_LAT : FLUSH_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SNOOP = 3'd1;
    localparam logic [2:0] RESP  = 3'd2;
    localparam logic [2:0] XFER  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [1:0] BUS_RDX  = 2'b01;
    localparam logic [1:0] BUS_UPGR = 2'b10;
    localparam logic [1:0] RESERVED = 2'b11;

    localparam logic [SRC_W-1:0] LAST_CORE = SRC_W'(NCORES - 1);
    localparam logic [CNT_W-1:0] MEM_CNT   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] FLUSH_CNT = CNT_W'(FLUSH_LAT - 1);

    logic [2:0]         state;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   owner;
    logic [1:0]         lat_type;
    logic [TAG_W-1:0]   lat_tag;
    logic [IDX_W-1:0]   lat_index;
    logic [CNT_W-1:0]   xfer_cnt;
    logic               shared_q;
    logic [31:0]        txn_cnt;

    logic [NCORES-1:0]  eligible;
    logic [NCORES-1:0]  hi_mask;
    logic [NCORES-1:0]  above;
    logic [NCORES-1:0]  cand;
    logic               any_eligible;
    logic [SRC_W-1:0]   winner;
    logic [1:0]         win_type;
    logic [TAG_W-1:0]   win_tag;
    logic [IDX_W-1:0]   win_index;
    logic [NCORES-1:0]  owner_oh;
    logic [NCORES-1:0]  masked_hit;
    logic [NCORES-1:0]  masked_dirty;
    logic               resp_shared;
    logic [CNT_W-1:0]   resp_cnt;

    for (genvar g = 0; g < NCORES; g++) begin : g_elig
        assign eligible[g] = req_valid_i[g] && (req_type_i[2*g +: 2] != RESERVED);
        assign owner_oh[g] = (owner == SRC_W'(g));
    end

    assign any_eligible = |eligible;

    // Round-robin: prefer eligible cores at or above rr_ptr, else wrap to the lowest.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < NCORES; k++) begin
            hi_mask[k] = (SRC_W'(k) >= rr_ptr);
        end
        above = eligible & hi_mask;
        cand  = (|above) ? above : eligible;
        winner = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            if (cand[k]) winner = SRC_W'(k);
        end
    end

    always_comb begin
        win_type  = '0;
        win_tag   = '0;
        win_index = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (winner == SRC_W'(k)) begin
                win_type  = req_type_i[2*k +: 2];
                win_tag   = req_tag_i[k*TAG_W +: TAG_W];
                win_index = req_index_i[k*IDX_W +: IDX_W];
            end
        end
    end

    assign masked_hit   = snoop_hit_i & ~owner_oh;
    assign masked_dirty = snoop_dirty_i & ~owner_oh;
    assign resp_shared  = (lat_type != BUS_RDX) && (|masked_hit);

    always_comb begin
        if (lat_type == BUS_UPGR) begin
            resp_cnt = '0;
        end else if (|masked_dirty) begin
            resp_cnt = FLUSH_CNT;
        end else begin
            resp_cnt = MEM_CNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            lat_type  <= '0;
            lat_tag   <= '0;
            lat_index <= '0;
            xfer_cnt  <= '0;
            shared_q  <= 1'b0;
            txn_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        state     <= SNOOP;
                        owner     <= winner;
                        lat_type  <= win_type;
                        lat_tag   <= win_tag;
                        lat_index <= win_index;
                        rr_ptr    <= (winner == LAST_CORE) ? '0 : winner + 1'b1;
                    end
                end
                SNOOP: state <= RESP;
                RESP: begin
                    state    <= XFER;
                    xfer_cnt <= resp_cnt;
                    shared_q <= resp_shared;
                end
                XFER: begin
                    if (xfer_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        xfer_cnt <= xfer_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    txn_cnt <= txn_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign bus_ready_o   = {NCORES{state == IDLE}};
    assign grant_o       = (state != IDLE) ? owner_oh : '0;
    assign snoop_valid_o = (state == SNOOP);
    assign snoop_type_o  = lat_type;
    assign snoop_tag_o   = lat_tag;
    assign snoop_index_o = lat_index;
    assign snoop_src_o   = owner;
    assign done_o        = (state == DONE) ? owner_oh : '0;
    assign txn_cnt_o     = txn_cnt;

    always_comb begin
        shared_o = 1'b0;
        if (state == RESP) begin
            shared_o = resp_shared;
        end else if ((state == XFER) || (state == DONE)) begin
            shared_o = shared_q;
        end
    end

endmodule
`default_nettype wire
